// File: rtl/rpatrol_input_ctrl_if.sv
// Signal bundle between the hps_io side (keyboard/joysticks) and the conditioned
// control outputs that feed the crazy_climber core.
interface rpatrol_input_ctrl_if;
  logic [10:0] ps2_key;
  logic [15:0] joystick_0;
  logic [15:0] joystick_1;
  logic        right1;
  logic        left1;
  logic        fire1;
  logic        right2;
  logic        left2;
  logic        fire2;
  logic        start1;
  logic        start2;
  logic        coin1;
  logic        coin_busy;
  logic [1:0]  coin_state;

  modport master (
    output ps2_key, joystick_0, joystick_1,
    input  right1, left1, fire1, right2, left2, fire2,
    input  start1, start2, coin1, coin_busy, coin_state
  );

  modport slave (
    input  ps2_key, joystick_0, joystick_1,
    output right1, left1, fire1, right2, left2, fire2,
    output start1, start2, coin1, coin_busy, coin_state
  );
endinterface

// File: rtl/rpatrol_input_ctrl.sv
// River Patrol input conditioning: PS/2 key decode, joystick merge, timed and
// rate-limited coin pulse, and Start gating until the credit has been registered.
module rpatrol_input_ctrl #(
  parameter int unsigned COIN_PULSE_CYCLES = 4800000,
  parameter int unsigned COIN_GAP_CYCLES   = 4800000,
  parameter bit          AUTO_COIN         = 1'b1
) (
  input logic                 clk_sys,
  input logic                 reset,
  rpatrol_input_ctrl_if.slave io
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    GAP   = 2'd2
  } coin_state_e;

  typedef struct packed {
    logic right1;
    logic left1;
    logic fire1;
    logic right2;
    logic left2;
    logic fire2;
    logic start1;
    logic start2;
    logic coin_a;
    logic coin_b;
  } keys_t;

  typedef struct packed {
    logic coin_busy;
    logic coin1;
    logic start2;
    logic start1;
    logic fire2;
    logic left2;
    logic right2;
    logic fire1;
    logic left1;
    logic right1;
  } outs_t;

  localparam logic [23:0] PULSE_LOAD = 24'(COIN_PULSE_CYCLES - 1);
  localparam logic [23:0] GAP_LOAD   = 24'(COIN_GAP_CYCLES - 1);

  keys_t       keys_q, keys_d;
  outs_t       outs_q, outs_d;
  coin_state_e state_q, state_d;
  logic [23:0] cnt_q, cnt_d;
  logic        pending_q, pending_d;
  logic        old_tog_q, old_tog_d;
  logic        req_dly_q, req_dly_d;

  logic        key_event;
  logic        pressed;
  logic [8:0]  code;
  logic        st1_raw, st2_raw;
  logic        req, trig, busy_nxt;
  logic        unused_bits;

  assign unused_bits = ^{io.joystick_0[15:7], io.joystick_0[3:2],
                         io.joystick_1[15:7], io.joystick_1[3:2]};

  always_comb begin
    keys_d    = keys_q;
    old_tog_d = io.ps2_key[10];
    key_event = io.ps2_key[10] != old_tog_q;
    pressed   = io.ps2_key[9];
    code      = io.ps2_key[8:0];
    if (key_event) begin
      // Arrow keys match with or without the extended prefix.
      casez (code)
        9'b?0111_0100:  keys_d.right1 = pressed;
        9'b?0110_1011:  keys_d.left1  = pressed;
        9'h029, 9'h014: keys_d.fire1  = pressed;
        9'h023:         keys_d.right2 = pressed;
        9'h01C:         keys_d.left2  = pressed;
        9'h015:         keys_d.fire2  = pressed;
        9'h005, 9'h016: keys_d.start1 = pressed;
        9'h006, 9'h01E: keys_d.start2 = pressed;
        9'h02E:         keys_d.coin_a = pressed;
        9'h036:         keys_d.coin_b = pressed;
        default:        ;
      endcase
    end

    st1_raw   = keys_q.start1 | io.joystick_0[5] | io.joystick_1[5];
    st2_raw   = keys_q.start2 | io.joystick_0[6] | io.joystick_1[6];
    req       = keys_q.coin_a | keys_q.coin_b | (AUTO_COIN & (st1_raw | st2_raw));
    req_dly_d = req;
    trig      = req & ~req_dly_q;

    state_d   = state_q;
    cnt_d     = cnt_q;
    pending_d = pending_q;
    case (state_q)
      IDLE: begin
        if (trig) begin
          state_d = PULSE;
          cnt_d   = PULSE_LOAD;
        end
      end
      PULSE: begin
        if (trig) pending_d = 1'b1;
        if (cnt_q == 24'd0) begin
          state_d = GAP;
          cnt_d   = GAP_LOAD;
        end else begin
          cnt_d = cnt_q - 24'd1;
        end
      end
      GAP: begin
        if (cnt_q == 24'd0) begin
          // A queued coin wins; a fresh trigger on the last gap cycle starts directly.
          if (pending_q || trig) begin
            pending_d = 1'b0;
            state_d   = PULSE;
            cnt_d     = PULSE_LOAD;
          end else begin
            state_d = IDLE;
          end
        end else begin
          if (trig) pending_d = 1'b1;
          cnt_d = cnt_q - 24'd1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 24'd0;
      end
    endcase

    busy_nxt         = state_d != IDLE;
    outs_d.right1    = keys_q.right1 | io.joystick_0[0];
    outs_d.left1     = keys_q.left1  | io.joystick_0[1];
    outs_d.fire1     = keys_q.fire1  | io.joystick_0[4];
    outs_d.right2    = keys_q.right2 | io.joystick_1[0];
    outs_d.left2     = keys_q.left2  | io.joystick_1[1];
    outs_d.fire2     = keys_q.fire2  | io.joystick_1[4];
    outs_d.start1    = st1_raw & ~(AUTO_COIN & busy_nxt);
    outs_d.start2    = st2_raw & ~(AUTO_COIN & busy_nxt);
    outs_d.coin1     = state_d == PULSE;
    outs_d.coin_busy = busy_nxt;
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      keys_q    <= '0;
      outs_q    <= '0;
      state_q   <= IDLE;
      cnt_q     <= 24'd0;
      pending_q <= 1'b0;
      req_dly_q <= 1'b0;
      old_tog_q <= io.ps2_key[10];
    end else begin
      keys_q    <= keys_d;
      outs_q    <= outs_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pending_q <= pending_d;
      req_dly_q <= req_dly_d;
      old_tog_q <= old_tog_d;
    end
  end

  assign io.right1     = outs_q.right1;
  assign io.left1      = outs_q.left1;
  assign io.fire1      = outs_q.fire1;
  assign io.right2     = outs_q.right2;
  assign io.left2      = outs_q.left2;
  assign io.fire2      = outs_q.fire2;
  assign io.start1     = outs_q.start1;
  assign io.start2     = outs_q.start2;
  assign io.coin1      = outs_q.coin1;
  assign io.coin_busy  = outs_q.coin_busy;
  assign io.coin_state = state_q;

endmodule

// File: tb/tb_rpatrol_input_ctrl.sv
// Bench for rpatrol_input_ctrl: one AUTO_COIN=1 instance (a) and one AUTO_COIN=0
// instance (b), short coin timings, cycle-stamped expectations checked by a monitor.
module tb_rpatrol_input_ctrl;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  rpatrol_input_ctrl_if ifa ();
  rpatrol_input_ctrl_if ifb ();

  rpatrol_input_ctrl #(.COIN_PULSE_CYCLES(4), .COIN_GAP_CYCLES(3), .AUTO_COIN(1'b1)) dut_a (
    .clk_sys (clk),
    .reset   (reset),
    .io      (ifa.slave)
  );

  rpatrol_input_ctrl #(.COIN_PULSE_CYCLES(4), .COIN_GAP_CYCLES(3), .AUTO_COIN(1'b0)) dut_b (
    .clk_sys (clk),
    .reset   (reset),
    .io      (ifb.slave)
  );

  // Observation bit layout: [9:0] instance a, [19:10] instance b.
  localparam logic [19:0] A_R1 = 20'h00001;
  localparam logic [19:0] A_L2 = 20'h00010;
  localparam logic [19:0] A_F2 = 20'h00020;
  localparam logic [19:0] A_S1 = 20'h00040;
  localparam logic [19:0] A_C  = 20'h00100;
  localparam logic [19:0] A_B  = 20'h00200;
  localparam logic [19:0] A_DIR = 20'h0003F;
  localparam logic [19:0] A_ALL = 20'h003FF;
  localparam logic [19:0] B_S2 = 20'h20000;
  localparam logic [19:0] B_C  = 20'h40000;
  localparam logic [19:0] B_B  = 20'h80000;
  localparam logic [19:0] ALL  = 20'hFFFFF;

  // ---------------- scoreboard ----------------
  typedef struct packed {
    int          cyc;
    logic [7:0]  tag;
    logic [19:0] mask;
    logic [19:0] val;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail = 0;

  function automatic string tag_name(input logic [7:0] tg);
    case (tg)
      8'd1:    return "reset_state";
      8'd2:    return "kb_right_press";
      8'd3:    return "kb_right_release";
      8'd4:    return "kb_right_074";
      8'd5:    return "kb_left2_only";
      8'd6:    return "joy_fire2";
      8'd7:    return "auto_coin";
      8'd8:    return "pending_sat";
      8'd9:    return "held_coin";
      8'd10:   return "reset_mid_pulse";
      8'd11:   return "no_event_after_reset";
      8'd12:   return "key_after_reset";
      8'd13:   return "nocoin_joy_start2";
      8'd14:   return "nocoin_key_start2";
      default: return "unknown";
    endcase
  endfunction

  task automatic push(input int c, input logic [19:0] v, input logic [19:0] m,
                      input logic [7:0] tg);
    exp_t e;
    int   idx;
    e.cyc  = c;
    e.tag  = tg;
    e.mask = m;
    e.val  = v & m;
    idx = exp_q.size();
    for (int i = 0; i < exp_q.size(); i++) begin
      if (exp_q[i].cyc > c) begin
        idx = i;
        break;
      end
    end
    exp_q.insert(idx, e);
  endtask

  function automatic logic [19:0] observe();
    return {ifb.coin_busy, ifb.coin1, ifb.start2, ifb.start1, ifb.fire2,
            ifb.left2, ifb.right2, ifb.fire1, ifb.left1, ifb.right1,
            ifa.coin_busy, ifa.coin1, ifa.start2, ifa.start1, ifa.fire2,
            ifa.left2, ifa.right2, ifa.fire1, ifa.left1, ifa.right1};
  endfunction

  always @(negedge clk) begin
    logic [19:0] obs;
    exp_t        e;
    obs = observe();
    while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
      e = exp_q.pop_front();
      n_checks++;
      if (e.cyc < cyc) begin
        n_fail++;
        $display("FAIL %s: expectation for cycle %0d not checked in time (now %0d)",
                 tag_name(e.tag), e.cyc, cyc);
      end else if (((obs & e.mask) ^ e.val) != 20'h0) begin
        n_fail++;
        $display("FAIL %s: cycle %0d actual=%05h expected=%05h mask=%05h",
                 tag_name(e.tag), cyc, obs & e.mask, e.val, e.mask);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic kev_a(input logic pressed, input logic [8:0] code);
    ifa.ps2_key = {~ifa.ps2_key[10], pressed, code};
    step();
  endtask

  task automatic kev_b(input logic pressed, input logic [8:0] code);
    ifb.ps2_key = {~ifb.ps2_key[10], pressed, code};
    step();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int t;
    logic [19:0] v;
    ifa.ps2_key = '0;
    ifa.joystick_0 = '0;
    ifa.joystick_1 = '0;
    ifb.ps2_key = '0;
    ifb.joystick_0 = '0;
    ifb.joystick_1 = '0;

    for (int i = 1; i <= 4; i++) push(i, '0, ALL, 8'd1);
    repeat (3) step();
    reset = 1'b0;
    repeat (2) step();

    // Keyboard press/release, 2-edge latency
    t = cyc;
    push(t + 1, '0, A_R1, 8'd2);
    push(t + 2, A_R1, A_R1, 8'd2);
    kev_a(1'b1, 9'h174);
    step();
    t = cyc;
    push(t + 1, A_R1, A_R1, 8'd3);
    push(t + 2, '0, A_R1, 8'd3);
    kev_a(1'b0, 9'h174);
    step();
    t = cyc;
    push(t + 2, A_R1, A_R1, 8'd4);
    kev_a(1'b1, 9'h074);
    step();
    t = cyc;
    push(t + 2, '0, A_R1, 8'd4);
    kev_a(1'b0, 9'h074);
    step();
    t = cyc;
    push(t + 2, A_L2, A_DIR, 8'd5);
    kev_a(1'b1, 9'h01C);
    step();
    t = cyc;
    push(t + 2, '0, A_DIR, 8'd5);
    kev_a(1'b0, 9'h01C);
    step();

    // Joystick path, 1-edge latency
    t = cyc;
    push(t, '0, A_F2, 8'd6);
    push(t + 1, A_F2, A_F2, 8'd6);
    ifa.joystick_1[4] = 1'b1;
    repeat (2) step();
    t = cyc;
    push(t + 1, '0, A_F2, 8'd6);
    ifa.joystick_1[4] = 1'b0;
    repeat (2) step();

    // Auto-coin from held joystick start
    t = cyc;
    push(t, '0, A_C | A_B | A_S1, 8'd7);
    for (int i = 0; i <= 10; i++) begin
      v = '0;
      if (i < 4)  v = v | A_C;
      if (i < 7)  v = v | A_B;
      if (i >= 7) v = v | A_S1;
      push(t + 1 + i, v, A_C | A_B | A_S1, 8'd7);
    end
    ifa.joystick_0[5] = 1'b1;
    repeat (11) step();
    t = cyc;
    push(t + 1, '0, A_C | A_B | A_S1, 8'd7);
    push(t + 2, '0, A_C | A_B | A_S1, 8'd7);
    ifa.joystick_0[5] = 1'b0;
    repeat (3) step();

    // Pending saturation: triggers at t+2, t+4, t+6, t+8
    t = cyc;
    for (int i = 1; i <= 18; i++) begin
      v = '0;
      if ((i >= 2 && i <= 5) || (i >= 9 && i <= 12)) v = v | A_C;
      if (i >= 2 && i <= 15) v = v | A_B;
      push(t + i, v, A_C | A_B, 8'd8);
    end
    for (int p = 0; p < 4; p++) begin
      kev_a(1'b1, 9'h02E);
      kev_a(1'b0, 9'h02E);
    end
    repeat (11) step();

    // Held coin key: exactly one pulse
    t = cyc;
    for (int i = 1; i <= 53; i++) begin
      v = '0;
      if (i >= 2 && i <= 5) v = v | A_C;
      if (i >= 2 && i <= 8) v = v | A_B;
      push(t + i, v, A_C | A_B, 8'd9);
    end
    kev_a(1'b1, 9'h036);
    repeat (49) step();
    kev_a(1'b0, 9'h036);
    repeat (3) step();

    // Reset during pulse cycle 2
    t = cyc;
    for (int i = 2; i <= 4; i++) push(t + i, A_C | A_B, A_C | A_B, 8'd10);
    push(t + 5, '0, A_ALL, 8'd10);
    push(t + 6, '0, A_ALL, 8'd10);
    for (int i = 7; i <= 10; i++) push(t + i, '0, A_ALL, 8'd11);
    kev_a(1'b1, 9'h02E);
    kev_a(1'b0, 9'h02E);
    repeat (2) step();
    reset = 1'b1;
    ifa.ps2_key = {1'b1, 1'b1, 9'h174};
    repeat (2) step();
    reset = 1'b0;
    repeat (4) step();
    t = cyc;
    push(t + 1, '0, A_R1, 8'd12);
    push(t + 2, A_R1, A_R1, 8'd12);
    kev_a(1'b1, 9'h174);
    step();
    t = cyc;
    push(t + 2, '0, A_R1, 8'd12);
    kev_a(1'b0, 9'h174);
    repeat (2) step();

    // AUTO_COIN = 0 instance: ungated start, no coin
    t = cyc;
    push(t, '0, B_S2, 8'd13);
    for (int i = 1; i <= 10; i++) push(t + i, B_S2, B_S2 | B_C | B_B, 8'd13);
    ifb.joystick_1[6] = 1'b1;
    repeat (10) step();
    t = cyc;
    push(t + 1, '0, B_S2 | B_C | B_B, 8'd13);
    ifb.joystick_1[6] = 1'b0;
    repeat (2) step();
    t = cyc;
    push(t + 1, '0, B_S2, 8'd14);
    for (int i = 2; i <= 6; i++) push(t + i, B_S2, B_S2 | B_C | B_B, 8'd14);
    kev_b(1'b1, 9'h01E);
    repeat (5) step();
    t = cyc;
    push(t + 2, '0, B_S2 | B_C | B_B, 8'd14);
    kev_b(1'b0, 9'h01E);
    repeat (2) step();

    // ---------------- final report ----------------
    for (int i = 0; i < 100 && exp_q.size() > 0; i++) step();
    if (exp_q.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
